// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result checker: function-code groups, per-op codes,
// checker FSM states and the pipelined transaction record.
package alu_pkg;

    localparam logic [1:0] GRP_ARITH = 2'b00;
    localparam logic [1:0] GRP_LOGIC = 2'b01;
    localparam logic [1:0] GRP_SHIFT = 2'b10;
    localparam logic [1:0] GRP_CMP   = 2'b11;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b011000;
    localparam logic [5:0] OP_OR    = 6'b011110;
    localparam logic [5:0] OP_XOR   = 6'b010110;
    localparam logic [5:0] OP_NOR   = 6'b010001;
    localparam logic [5:0] OP_PASSA = 6'b011010;
    localparam logic [5:0] OP_SLL   = 6'b100000;
    localparam logic [5:0] OP_SRL   = 6'b100001;
    localparam logic [5:0] OP_SRA   = 6'b100011;
    localparam logic [5:0] OP_EQ    = 6'b110011;
    localparam logic [5:0] OP_NE    = 6'b110001;
    localparam logic [5:0] OP_LT    = 6'b110101;
    localparam logic [5:0] OP_LEZ   = 6'b111101;
    localparam logic [5:0] OP_LTZ   = 6'b111011;
    localparam logic [5:0] OP_GTZ   = 6'b111111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic [5:0]  alufun;
        logic        sign;
    } txn_t;

endpackage

// File: rtl/alu_golden.sv
// Combinational golden ALU: expected result for a/b/alufun/sign, plus an illegal-code flag.
module alu_golden
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [5:0]  alufun,
    input  logic        sign,
    output logic [31:0] exp,
    output logic        illegal
);

    logic lt;

    always_comb begin
        exp     = '0;
        illegal = 1'b0;
        lt      = sign ? ($signed(a) < $signed(b)) : (a < b);
        case (alufun[5:4])
            // Arithmetic only looks at bit 0; bits 3:1 are don't-care.
            GRP_ARITH: exp = alufun[0] ? a - b : a + b;
            GRP_LOGIC: begin
                case (alufun)
                    OP_AND:   exp = a & b;
                    OP_OR:    exp = a | b;
                    OP_XOR:   exp = a ^ b;
                    OP_NOR:   exp = ~(a | b);
                    OP_PASSA: exp = a;
                    default:  illegal = 1'b1;
                endcase
            end
            GRP_SHIFT: begin
                case (alufun[1:0])
                    2'b00:   exp = b << a[4:0];
                    2'b01:   exp = b >> a[4:0];
                    2'b11:   exp = $unsigned($signed(b) >>> a[4:0]);
                    default: illegal = 1'b1;
                endcase
            end
            GRP_CMP: begin
                case (alufun)
                    OP_EQ:   exp = {31'b0, a == b};
                    OP_NE:   exp = {31'b0, a != b};
                    OP_LT:   exp = {31'b0, lt};
                    OP_LEZ:  exp = {31'b0, $signed(a) <= 32'sd0};
                    OP_LTZ:  exp = {31'b0, a[31]};
                    OP_GTZ:  exp = {31'b0, $signed(a) > 32'sd0};
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_result_checker.sv
// Two-stage ALU response checker: registers the ALU bus, compares against alu_golden,
// keeps saturating counters, a first-fail record and an optional halt-on-fail FSM.
module alu_result_checker
    import alu_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic [5:0]       alufun,
    input  logic             sign,
    input  logic [31:0]      z,
    input  logic             clear,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic             halted,
    output logic             ff_valid,
    output logic [5:0]       ff_alufun,
    output logic [31:0]      ff_a,
    output logic [31:0]      ff_b,
    output logic [31:0]      ff_z,
    output logic [31:0]      ff_exp
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    state_t      state;
    logic [1:0]  vld_pipe;
    txn_t        s1;
    logic [31:0] exp_z;
    logic        illegal;
    logic        match;
    logic        retire;
    logic        halt_now;

    alu_golden u_golden (
        .a       (s1.a),
        .b       (s1.b),
        .alufun  (s1.alufun),
        .sign    (s1.sign),
        .exp     (exp_z),
        .illegal (illegal)
    );

    // Stage 1 is only ever loaded in RUN, so a valid stage-1 entry always retires.
    assign match    = illegal || (exp_z == s1.z);
    assign retire   = vld_pipe[0];
    assign halt_now = STOP_ON_FAIL && retire && !match;

    assign chk_valid = vld_pipe[1];
    assign halted    = (state == ST_HALT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            vld_pipe    <= '0;
            s1          <= '0;
            chk_pass    <= 1'b0;
            txn_cnt     <= '0;
            err_cnt     <= '0;
            illegal_cnt <= '0;
            ff_valid    <= 1'b0;
            ff_alufun   <= '0;
            ff_a        <= '0;
            ff_b        <= '0;
            ff_z        <= '0;
            ff_exp      <= '0;
        end else if (clear) begin
            state       <= ST_RUN;
            vld_pipe    <= '0;
            chk_pass    <= 1'b0;
            txn_cnt     <= '0;
            err_cnt     <= '0;
            illegal_cnt <= '0;
            ff_valid    <= 1'b0;
            ff_alufun   <= '0;
            ff_a        <= '0;
            ff_b        <= '0;
            ff_z        <= '0;
            ff_exp      <= '0;
        end else begin
            // A transaction arriving on the halting edge is dropped along with the pipe.
            vld_pipe[0] <= in_valid && (state == ST_RUN) && !halt_now;
            vld_pipe[1] <= retire;
            if (in_valid)
                s1 <= '{a: a, b: b, z: z, alufun: alufun, sign: sign};
            if (retire) begin
                chk_pass <= match;
                txn_cnt  <= sat_inc(txn_cnt);
                if (illegal)
                    illegal_cnt <= sat_inc(illegal_cnt);
                if (!match) begin
                    err_cnt <= sat_inc(err_cnt);
                    if (!ff_valid) begin
                        ff_valid  <= 1'b1;
                        ff_alufun <= s1.alufun;
                        ff_a      <= s1.a;
                        ff_b      <= s1.b;
                        ff_z      <= s1.z;
                        ff_exp    <= exp_z;
                    end
                end
                if (halt_now)
                    state <= ST_HALT;
            end
        end
    end

endmodule

// File: doc/alu_result_checker.md
# alu_result_checker

Synthesizable response checker that sits beside the combinational ALU in the MIPS datapath (or on a board BIST harness). It consumes the operand/function bus driven into the ALU together with the ALU's output `Z` and recomputes the golden result. It then reports pass/fail per transaction and keeps transaction, error and illegal-op counters. It captures the first failing transaction for debug readback.

## Interface
Parameters:
- `CNT_W`, 16, width of all counters (saturating).
- `STOP_ON_FAIL`, 0, when 1 the checker halts after the first mismatch until `clear`.

Ports:
- `clk` in 1: system clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: a/b/alufun/sign/z form one transaction this cycle.
- `a`, `b` in 32: ALU operands A, B.
- `alufun` in 6: ALU function code.
- `sign` in 1: 1 = signed compare.
- `z` in 32: ALU result under test.
- `clear` in 1: synchronous clear of counters, first-fail record, FSM to RUN.
- `chk_valid` out 1: verdict valid.
- `chk_pass` out 1: verdict (1 = match).
- `txn_cnt`, `err_cnt`, `illegal_cnt` out CNT_W: counters.
- `halted` out 1: FSM in HALT.
- `ff_valid` out 1: first-fail record valid.
- `ff_alufun` out 6; `ff_a`, `ff_b`, `ff_z`, `ff_exp` out 32: first failing transaction and its expected value.

## Operation
- Golden model decodes ALUFun[5:4]:
  - 00 arith: [0]=0 A+B, [0]=1 A−B, modulo 2^32, no overflow flag.
  - 01 logic on [3:0]: 1000 AND, 1110 OR, 0110 XOR, 0001 NOR, 1010 pass A.
  - 10 shift B by A[4:0] on [1:0]: 00 SLL, 01 SRL, 11 SRA.
  - 11 compare on [3:0], result in bit 0, bits 31:1 zero: 0011 EQ, 0001 NE, 0101 LT (signed if `sign`, else unsigned), 1101 LEZ, 1011 LTZ, 1111 GTZ. The zero tests are always signed on A.
  - Any other code is illegal.
- Illegal op: `illegal_cnt`+1 and `txn_cnt`+1. `chk_valid` pulses with `chk_pass`=1; not an error.
- Mismatch: `err_cnt`+1. If `ff_valid`=0, latch the ff_* fields and set `ff_valid`. Later failures never overwrite the record.
- FSM states:
  - RUN: accept transactions. On mismatch with STOP_ON_FAIL=1, go to HALT.
  - HALT: `in_valid` is ignored and counters are frozen. `clear` returns to RUN.
- Counters saturate at all-ones.
- `clear` has priority over a verdict retiring in the same cycle; that verdict is discarded.

## Timing
- Two-stage pipeline:
  - Edge 1 registers the inputs.
  - Expected is computed from the registered inputs.
  - Edge 2 registers the verdict.
  - A transaction sampled at edge k gives `chk_valid`=1 for one cycle after edge k+1. Counters and ff_* update on that same edge.
- Full throughput: back-to-back `in_valid` gives back-to-back verdicts; no backpressure.
- In HALT, the pipeline drains. Transactions already in flight when the halting mismatch retires are dropped: no verdict, no count.
- Reset values: all outputs 0, FSM in RUN, pipeline valid bits 0. Reset mid-transaction discards in-flight work.
- `clear` also kills both pipeline valid bits.

## Structure
- Shared package `alu_pkg`:
  - ALUFun group constants (ARITH, LOGIC, SHIFT, CMP).
  - Per-op 6-bit codes.
  - FSM state enum.
- Sub-module `alu_golden`: purely combinational. Inputs a, b, alufun, sign; outputs exp[31:0] and illegal. It is reusable by other benches.
- The top holds the pipeline registers, FSM, counters and first-fail record.

## Test plan
- ADD pass: a=5, b=0, alufun=000000, z=5, one `in_valid`. Two cycles later: chk_valid=1, chk_pass=1, txn_cnt=1, err_cnt=0.
- SUB fail: a=5, b=0, alufun=000001, z=4. Response: chk_pass=0, err_cnt=1, ff_valid=1, ff_exp=5, ff_z=4. A second failure leaves ff_* unchanged.
- Shift/logic sweep (each with correct z → all pass):
  - SRA: alufun=100011, a=4, b=32'h8000_0000, z=32'hF800_0000.
  - NOR: alufun=010001, a=5, b=0, z=32'hFFFF_FFFA.
- Signed vs unsigned LT: alufun=110101, a=32'hFFFF_FFFF, b=1. Response: sign=1 expects 1, sign=0 expects 0. Feeding the wrong z must fail.
- Illegal code 010000: illegal_cnt=1, txn_cnt=1, err_cnt=0, chk_pass=1.
- STOP_ON_FAIL=1: fail, then 3 more transactions. Response: halted=1, txn_cnt frozen. After `clear`: halted=0, all counters 0, ff_valid=0. Asserting reset during back-to-back traffic gives no verdict after reset.
